pkt_out_port: RTL

Output-port packet controller for the router, placed directly downstream of the round-robin arbiter (`rr_arb`).
- Presents the input clients' packet-valid lines to the arbiter as requests and pulses the arbiter's `cycle` once per arbitration.
- Latches the one-hot grant and holds it for the whole packet.
- Forwards the owner's beats through a registered output stage with ready/valid backpressure.
- A packet is never interleaved with another client's beats.

---
 rtl/pkt_out_port_pkg.sv | 10 +
 rtl/pkt_out_port_onehot_mux.sv | 19 +
 rtl/pkt_out_port.sv | 89 ++++++++
 3 files changed

// File: rtl/pkt_out_port_pkg.sv
// Shared router definitions for the output-port packet controller.
// The port FSM needs only a 1-bit state: IDLE while arbitrating, BUSY while forwarding a packet.
package pkt_out_port_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } port_state_e;

endpackage

// File: rtl/pkt_out_port_onehot_mux.sv
// Combinational one-hot selector: ORs together the DW-bit slices whose select bit is set.
// The output is zero when the select vector is zero.
module onehot_mux #(
    parameter int N  = 2,
    parameter int DW = 8
) (
    input  logic [N-1:0]    sel,
    input  logic [N*DW-1:0] din,
    output logic [DW-1:0]   dout
);

    always_comb begin
        dout = '0;
        for (int i = 0; i < N; i++) begin
            if (sel[i]) dout = dout | din[i*DW +: DW];
        end
    end

endmodule

// File: rtl/pkt_out_port.sv
// Output-port packet controller: arbitrates once per packet, locks the grant for the
// whole packet and forwards the owner's beats through a registered ready/valid stage.
module pkt_out_port
    import pkt_out_port_pkg::*;
#(
    parameter int CLIENTS = 2,
    parameter int DW      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CLIENTS-1:0]    in_valid,
    input  logic [CLIENTS*DW-1:0] in_data,
    input  logic [CLIENTS-1:0]    in_last,
    output logic [CLIENTS-1:0]    in_ready,
    output logic [CLIENTS-1:0]    arb_req,
    output logic                  arb_cycle,
    input  logic [CLIENTS-1:0]    arb_gnt,
    output logic                  out_valid,
    output logic [DW-1:0]         out_data,
    output logic                  out_last,
    input  logic                  out_ready
);

    port_state_e        state, state_nxt;
    logic [CLIENTS-1:0] owner;
    logic [DW-1:0]      sel_data;
    logic               sel_last;
    logic               acc;

    onehot_mux #(.N(CLIENTS), .DW(DW)) u_data_mux (
        .sel  (owner),
        .din  (in_data),
        .dout (sel_data)
    );

    onehot_mux #(.N(CLIENTS), .DW(1)) u_last_mux (
        .sel  (owner),
        .din  (in_last),
        .dout (sel_last)
    );

    assign arb_req = in_valid;

    // arb_cycle only pulses in IDLE so the arbiter pointer moves once per packet.
    always_comb begin
        state_nxt = state;
        arb_cycle = 1'b0;
        in_ready  = '0;
        acc       = 1'b0;
        case (state)
            IDLE: begin
                arb_cycle = |in_valid;
                if (arb_cycle && (|arb_gnt)) state_nxt = BUSY;
            end
            BUSY: begin
                in_ready = owner & {CLIENTS{!out_valid || out_ready}};
                acc      = |(in_valid & in_ready);
                if (acc && sel_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            owner <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && arb_cycle && (|arb_gnt)) owner <= arb_gnt;
        end
    end

    // Output stage only loads when empty or draining, so an unaccepted beat is never lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (acc) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_last  <= sel_last;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
